mono_sample_framer: RTL and testbench
=====================================

// Module: mono_sample_framer
// PURPOSE
//  Downstream of the stereo-to-mono converter. Collects mono_sample/mono_sample_valid pulses into
//  fixed-length frames using ping-pong banks and streams each complete frame out on an AXI4-Stream
//  master (TLAST on final word) to the spectrum/FFT stage. Write side never stalls; overflow drops.
// PARAMETERS
//  DATA_WIDTH  32   sample width, matches upstream converter
//  FRAME_LEN   256  samples per frame; power of two, >= 2
//  (local) ADDR_WIDTH = $clog2(FRAME_LEN)
// PORTS
//  M_AXIS_ACLK        in   1           sole clock
//  M_AXIS_ARESETN     in   1           synchronous, active-low reset
//  mono_sample_valid  in   1           one-cycle strobe: mono_sample is valid
//  mono_sample        in   DATA_WIDTH  mono sample
//  M_AXIS_TVALID      out  1           frame word valid
//  M_AXIS_TDATA       out  DATA_WIDTH  frame word, oldest sample first
//  M_AXIS_TLAST       out  1           high on word FRAME_LEN-1 of each frame
//  M_AXIS_TREADY      in   1           downstream accept
//  sample_dropped     out  1           one-cycle pulse: incoming sample discarded (overflow)
//  drop_count         out  16          only when MONO_FRAMER_DROP_COUNT_EN defined
// BEHAVIOUR
//  - One clock, synchronous active-low reset. Reset: TVALID=0, TLAST=0, TDATA=0, sample_dropped=0,
//    drop_count=0, both banks empty, wr_bank=0, rd_bank=0, indices 0, reader IDLE. Reset mid-frame
//    discards partial and pending frames; TVALID low the cycle after reset is sampled.
//  - Storage: 2 banks x FRAME_LEN x DATA_WIDTH; flag full[b] per bank.
//  - Writer: on mono_sample_valid with full[wr_bank]==0, store at [wr_bank][wr_idx], wr_idx++.
//    Store of index FRAME_LEN-1: full[wr_bank]<=1, wr_bank toggles, wr_idx<=0 (wrap).
//    mono_sample_valid while full[wr_bank]==1: sample dropped, sample_dropped=1 next cycle, wr_idx held.
//  - Reader FSM: IDLE -> (full[rd_bank]) FETCH -> STREAM -> IDLE.
//    IDLE: TVALID=0. FETCH: one cycle, reads word 0 into TDATA register.
//    STREAM: TVALID=1; TDATA/TLAST held stable while TREADY=0 (AXIS rule).
//    On TVALID&TREADY: rd_idx++, next word loaded same edge -> 1 beat/cycle sustained.
//    Handshake with TLAST=1: full[rd_bank]<=0, rd_bank toggles, -> IDLE (one idle cycle min).
//  - Latency: completing write at edge N -> TVALID=1 after edge N+2 (IDLE->FETCH->STREAM).
//  - Simultaneous: reader releasing bank B in same cycle a sample arrives for B (B currently
//    full) -> sample is dropped (release takes effect next cycle). Writer completing bank A in the
//    same cycle reader finishes bank B: both take effect; reader sees full[A] next IDLE cycle.
//  - Data path is pass-through; no arithmetic on samples, no width change.
// CONFIGURATION
//  MONO_FRAMER_DROP_COUNT_EN defined: drop_count port present; increments by 1 per dropped
//    sample, saturates at 16'hFFFF, cleared only by reset.
//  Undefined: drop_count port and counter absent; sample_dropped pulse still present.
// TESTING  (FRAME_LEN=8, DATA_WIDTH=32)
//  - 8 valids, data 1..8, TREADY=1 -> TVALID 2 cycles after 8th, TDATA 1..8 in consecutive
//    cycles, TLAST only on 8; sample_dropped never pulses.
//  - Same frame, TREADY toggled 1,0,0,1,... -> each word held stable while stalled; order 1..8,
//    exactly 8 handshakes, one TLAST.
//  - TREADY=0, 24 valids (data 1..24) -> frames 1..8 and 9..16 buffered, samples 17..24 each
//    pulse sample_dropped; drop_count=8 (macro on); then TREADY=1 -> output 1..8 then 9..16.
//  - 8 valids then reset asserted during beat 3 of output -> TVALID=0 next cycle; post-reset
//    frame 100..107 streams cleanly, TLAST on 107.
//  - Continuous valid every 2 cycles, TREADY=1, 5 frames -> no drops, 40 words in order, 5 TLASTs.
//  - Macro on, >65535 drops -> drop_count stays 16'hFFFF.

Source files
------------

// File: rtl/mono_sample_framer.sv
// Ping-pong frame buffer: gathers mono samples into FRAME_LEN-word frames and streams them on AXI4-Stream.
// Optional drop counter port is enabled by defining MONO_FRAMER_DROP_COUNT_EN.
module mono_sample_framer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAME_LEN  = 256
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  mono_sample_valid,
    input  logic [DATA_WIDTH-1:0] mono_sample,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  sample_dropped
`ifdef MONO_FRAMER_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    localparam int unsigned ADDR_WIDTH = $clog2(FRAME_LEN);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [2][FRAME_LEN];
    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_en;
    logic                  wr_done;
    logic                  drop;
    logic                  load;
    logic                  rd_done;

    assign wr_en   = mono_sample_valid && !full[wr_bank];
    assign wr_done = wr_en && (wr_idx == LAST_IDX);
    assign drop    = mono_sample_valid && full[wr_bank];

    always_ff @(posedge M_AXIS_ACLK) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= mono_sample;
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            wr_bank        <= 1'b0;
            wr_idx         <= '0;
            sample_dropped <= 1'b0;
        end else begin
            sample_dropped <= drop;
            if (wr_en) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    // Writer only fills a non-full bank and reader only releases a full one, so the bits never collide.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            full <= '0;
        end else begin
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        rd_done    = 1'b0;
        rd_addr    = rd_idx;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                load       = 1'b1;
                rd_addr    = '0;
                state_next = STREAM;
            end
            STREAM: begin
                if (M_AXIS_TREADY) begin
                    if (M_AXIS_TLAST) begin
                        rd_done    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        load    = 1'b1;
                        rd_addr = rd_idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign M_AXIS_TVALID = (state == STREAM);

    // Output word register is only reloaded on FETCH or an accepted beat, so it holds during stalls.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            M_AXIS_TDATA <= '0;
            M_AXIS_TLAST <= 1'b0;
            rd_idx       <= '0;
            rd_bank      <= 1'b0;
        end else begin
            if (load) begin
                M_AXIS_TDATA <= mem[rd_bank][rd_addr];
                M_AXIS_TLAST <= (rd_addr == LAST_IDX);
                rd_idx       <= rd_addr;
            end
            if (rd_done) begin
                rd_bank      <= ~rd_bank;
                M_AXIS_TLAST <= 1'b0;
            end
        end
    end

`ifdef MONO_FRAMER_DROP_COUNT_EN
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mono_sample_framer.sv
// Directed self-checking bench for mono_sample_framer with FRAME_LEN=8.
// Drop counter checks are active when MONO_FRAMER_DROP_COUNT_EN is defined.
module tb_mono_sample_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [31:0] sample;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        tready;
    logic        dropped;
`ifdef MONO_FRAMER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;
    int drops  = 0;

    logic [31:0] beat_data[$];
    logic        beat_last[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    mono_sample_framer #(.DATA_WIDTH(32), .FRAME_LEN(8)) dut (
        .M_AXIS_ACLK       (clk),
        .M_AXIS_ARESETN    (rst_n),
        .mono_sample_valid (sample_valid),
        .mono_sample       (sample),
        .M_AXIS_TVALID     (tvalid),
        .M_AXIS_TDATA      (tdata),
        .M_AXIS_TLAST      (tlast),
        .M_AXIS_TREADY     (tready),
        .sample_dropped    (dropped)
`ifdef MONO_FRAMER_DROP_COUNT_EN
        ,
        .drop_count        (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: verify stall stability, record the beat accepted at the coming edge, advance.
    task automatic tick();
        if (prev_stall) begin
            chk("stall_tvalid", tvalid, 1'b1);
            chk("stall_tdata", tdata, prev_data);
            chk("stall_tlast", tlast, prev_last);
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
        if (tvalid && tready) begin
            beat_data.push_back(tdata);
            beat_last.push_back(tlast);
        end
        if (dropped) drops++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample       = base + 32'(i);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int budget);
        for (int i = 0; i < budget && beat_data.size() < n; i++) tick();
        chk("beat_count", 32'(beat_data.size()), 32'(n));
    endtask

    task automatic check_beats(input int first, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            chk("beat_data", beat_data[first + i], base + 32'(i));
            chk("beat_last", beat_last[first + i], (i == n - 1));
        end
    endtask

    task automatic clear_beats();
        beat_data.delete();
        beat_last.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        tready       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_dropped", dropped, 1'b0);
`ifdef MONO_FRAMER_DROP_COUNT_EN
        chk("rst_drop_count", drop_count, 16'h0);
`endif
        rst_n = 1'b1;

        // Single frame, TREADY held high: latency of two edges, then eight back-to-back beats.
        send(32'd1, 8);
        chk("lat_n0", tvalid, 1'b0);
        tick();
        chk("lat_n1", tvalid, 1'b0);
        tick();
        chk("lat_n2", tvalid, 1'b1);
        chk("first_tdata", tdata, 32'd1);
        chk("first_tlast", tlast, 1'b0);
        repeat (8) tick();
        chk("f1_count", 32'(beat_data.size()), 32'd8);
        check_beats(0, 32'd1, 8);
        chk("f1_idle", tvalid, 1'b0);
        chk("f1_drops", 32'(drops), 32'd0);

        // Same frame under TREADY pattern 1,0,0,...
        clear_beats();
        send(32'd1, 8);
        for (int k = 0; k < 80 && beat_data.size() < 8; k++) begin
            tready = (k % 3 == 0);
            tick();
        end
        tready = 1'b1;
        repeat (3) tick();
        chk("f2_count", 32'(beat_data.size()), 32'd8);
        check_beats(0, 32'd1, 8);

        // Overflow: both banks fill, eight samples dropped, then both frames drain in order.
        clear_beats();
        tready = 1'b0;
        send(32'd1, 24);
        tick();
        chk("ovf_drops", 32'(drops), 32'd8);
        chk("ovf_pulse_done", dropped, 1'b0);
`ifdef MONO_FRAMER_DROP_COUNT_EN
        chk("ovf_drop_count", drop_count, 16'd8);
`endif
        tready = 1'b1;
        drain(16, 100);
        check_beats(0, 32'd1, 8);
        check_beats(8, 32'd9, 8);

        // Reset while beat 3 is presented discards the frame in flight.
        clear_beats();
        send(32'd201, 8);
        for (int i = 0; i < 20 && !tvalid; i++) tick();
        chk("rst_wait_valid", tvalid, 1'b1);
        tick();
        tick();
        chk("beat3_tdata", tdata, 32'd203);
        rst_n = 1'b0;
        tick();
        chk("midrst_tvalid", tvalid, 1'b0);
        chk("midrst_tlast", tlast, 1'b0);
        chk("midrst_tdata", tdata, 32'h0);
`ifdef MONO_FRAMER_DROP_COUNT_EN
        chk("midrst_drop_count", drop_count, 16'h0);
`endif
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", tvalid, 1'b0);
        clear_beats();
        send(32'd100, 8);
        drain(8, 30);
        check_beats(0, 32'd100, 8);

        // Continuous writes every other cycle across five frames.
        clear_beats();
        drops = 0;
        for (int i = 0; i < 40; i++) begin
            sample_valid = 1'b1;
            sample       = 32'd1000 + 32'(i);
            tick();
            sample_valid = 1'b0;
            tick();
        end
        drain(40, 60);
        for (int f = 0; f < 5; f++) check_beats(f * 8, 32'd1000 + 32'(f * 8), 8);
        chk("cont_drops", 32'(drops), 32'd0);

`ifdef MONO_FRAMER_DROP_COUNT_EN
        // Saturation: 16 samples fill both banks, then 65534, 1 and 5 further drops.
        tready       = 1'b0;
        sample_valid = 1'b1;
        sample       = 32'hABCD;
        repeat (16 + 65534) @(posedge clk);
        #1;
        chk("sat_fffe", drop_count, 16'hFFFE);
        @(posedge clk);
        #1;
        chk("sat_ffff", drop_count, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_hold", drop_count, 16'hFFFF);
        sample_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
